viewport_map: RTL

Downstream neighbour of the normalization stage in the render pipeline. It takes the four normalized vertices (X/Y/Z, signed 16-bit) produced for one primitive, maps each to integer screen coordinates and a 16-bit depth, and flags off-screen coordinates. Results stream one vertex per transfer to the rasterizer over a valid/ready handshake.

---
 rtl/viewport_pkg.sv | 17 +
 rtl/viewport_axis_map.sv | 41 ++++
 rtl/viewport_map.sv | 118 +++++++++++
 3 files changed

// File: rtl/viewport_pkg.sv
// viewport_pkg: constants and types shared by the viewport mapping stage.
//   FRAC    : fractional bits of the normalized coordinate format
//   NDC_ONE : fixed-point value of NDC +1.0
//   coord_t : signed 16-bit normalized coordinate
//   state_t : sequencer states
package viewport_pkg;
  localparam int FRAC    = 13;
  localparam int NDC_ONE = 1 << FRAC;

  typedef logic signed [15:0] coord_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } state_t;
endpackage

// File: rtl/viewport_axis_map.sv
// viewport_axis_map: maps one normalized coordinate onto a screen axis.
//   coord : signed normalized coordinate (NDC +-1.0 = +-NDC_ONE)
//   scale : axis length in pixels (<= 1024)
//   flip  : 1 maps +1.0 to row 0 (screen Y grows downward)
//   val   : clamped pixel coordinate, 0..scale-1
//   clip  : coordinate lies outside +-1.0
module viewport_axis_map
  import viewport_pkg::*;
#(
  parameter int XYW = 10
) (
  input  coord_t           coord,
  input  logic [10:0]      scale,
  input  logic             flip,
  output logic [XYW-1:0]   val,
  output logic             clip
);
  logic signed [17:0] c_ext;
  logic signed [17:0] s;
  logic [27:0]        prod;
  logic [27:0]        scaled;

  always_comb begin
    c_ext  = {{2{coord[15]}}, coord};
    // Shift into 0..2*NDC_ONE; flipping mirrors the axis around the centre.
    s      = flip ? (18'(NDC_ONE) - c_ext) : (c_ext + 18'(NDC_ONE));
    prod   = {11'b0, s[16:0]} * {17'b0, scale};
    scaled = prod >> (FRAC + 1);
    val    = '0;
    clip   = 1'b0;
    if (s < 0) begin
      clip = 1'b1;
    end else if (scaled >= {17'b0, scale}) begin
      // Exactly +1.0 lands one past the last pixel; clamp it without clipping.
      val  = XYW'(scale - 11'd1);
      clip = (s > 18'(2 * NDC_ONE));
    end else begin
      val  = scaled[XYW-1:0];
    end
  end
endmodule

// File: rtl/viewport_map.sv
// viewport_map: maps the four normalized vertices of a primitive to screen
// coordinates and depth, streaming one vertex per valid/ready transfer.
//   CLK, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : primitive handshake (accepted only in IDLE)
//   vtxN_X/Y/Z         : signed normalized coordinates of vertex N
//   out_valid/out_ready: per-vertex handshake to the rasterizer
//   out_idx/out_last   : vertex index 0..3, last-vertex flag
//   out_x/out_y/out_z  : screen x, screen y (top row 0), unsigned depth
//   out_clip           : some axis of the vertex was outside +-1.0
//   busy               : a primitive is in flight
module viewport_map
  import viewport_pkg::*;
#(
  parameter int SCR_W = 640,
  parameter int SCR_H = 480,
  parameter int XYW   = 10
) (
  input  logic           CLK,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  coord_t         vtx1_X, vtx1_Y, vtx1_Z,
  input  coord_t         vtx2_X, vtx2_Y, vtx2_Z,
  input  coord_t         vtx3_X, vtx3_Y, vtx3_Z,
  input  coord_t         vtx4_X, vtx4_Y, vtx4_Z,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [1:0]     out_idx,
  output logic [XYW-1:0] out_x,
  output logic [XYW-1:0] out_y,
  output logic [15:0]    out_z,
  output logic           out_clip,
  output logic           out_last,
  output logic           busy
);
  state_t             state, nxt;
  logic [1:0]         idx;
  logic [3:0][15:0]   lx, ly, lz;
  coord_t             sel_x, sel_y, sel_z;
  logic [XYW-1:0]     mx, my;
  logic [15:0]        mz;
  logic               cx, cy, cz;
  logic signed [17:0] zs;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == EMIT);
  assign busy      = (state != IDLE);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = CALC;
      CALC:    nxt = EMIT;
      EMIT:    if (out_ready) nxt = (idx == 2'd3) ? IDLE : CALC;
      default: nxt = IDLE;
    endcase
  end

  // Primitive capture: inputs are only sampled on the accept edge.
  always_ff @(posedge CLK) begin
    if (!rst && state == IDLE && in_valid) begin
      lx <= {vtx4_X, vtx3_X, vtx2_X, vtx1_X};
      ly <= {vtx4_Y, vtx3_Y, vtx2_Y, vtx1_Y};
      lz <= {vtx4_Z, vtx3_Z, vtx2_Z, vtx1_Z};
    end
  end

  assign sel_x = lx[idx];
  assign sel_y = ly[idx];
  assign sel_z = lz[idx];

  viewport_axis_map #(.XYW(XYW)) u_map_x (
    .coord(sel_x), .scale(11'(SCR_W)), .flip(1'b0), .val(mx), .clip(cx)
  );
  viewport_axis_map #(.XYW(XYW)) u_map_y (
    .coord(sel_y), .scale(11'(SCR_H)), .flip(1'b1), .val(my), .clip(cy)
  );

  // Depth: (Z + 1.0) scaled by 4 spans 0..65536; saturate to 16 bits.
  always_comb begin
    zs = {{2{sel_z[15]}}, sel_z} + 18'(NDC_ONE);
    mz = '0;
    cz = 1'b0;
    if (zs < 0) begin
      cz = 1'b1;
    end else if (zs >= 18'(2 * NDC_ONE)) begin
      mz = 16'hFFFF;
      cz = (zs > 18'(2 * NDC_ONE));
    end else begin
      mz = {zs[13:0], 2'b00};
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      out_idx  <= '0;
      out_x    <= '0;
      out_y    <= '0;
      out_z    <= '0;
      out_clip <= 1'b0;
      out_last <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && in_valid) idx <= '0;
      if (state == CALC) begin
        out_idx  <= idx;
        out_x    <= mx;
        out_y    <= my;
        out_z    <= mz;
        out_clip <= cx | cy | cz;
        out_last <= (idx == 2'd3);
      end
      if (state == EMIT && out_ready && idx != 2'd3) idx <= idx + 2'd1;
    end
  end
endmodule
